// File: rtl/im_fetch_mem.sv
// Parametrised instruction memory: valid/ready fetch port with a one-entry output register,
// byte-enabled loader write port, and a one-word-per-cycle clear engine after reset. Optional parity: IM_PARITY_EN.
module im_fetch_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fetch_req,
   input  logic [AW-1:0]       fetch_addr,
   output logic                fetch_ready,
   output logic                fetch_valid,
   output logic [DATA_W-1:0]   fetch_data,
   input  logic                fetch_accept,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_be,
   output logic                busy,
`ifdef IM_PARITY_EN
   output logic                par_err,
   input  logic                par_inject,
`endif
   output logic                addr_err
);

   localparam int NB = DATA_W / 8;
`ifdef IM_PARITY_EN
   localparam int LW = 9;
`else
   localparam int LW = 8;
`endif
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t          state_reg, state_next;
   logic [AW-1:0]   clr_cnt_reg, clr_cnt_next;
   logic            fetch_valid_reg;
   logic            addr_err_reg;
   logic            run;
   logic            fetch_fire;
   logic            fetch_in_range;
   logic            wr_in_range;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [NB-1:0]   mem_be;
   logic [NB-1:0]   lane_perr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= CLEAR;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      case (state_reg)
         CLEAR: begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == LAST_ADDR) begin
               state_next   = RUN;
               clr_cnt_next = '0;
            end
         end
         RUN: begin
            state_next = RUN;
         end
      endcase
   end

   assign busy           = (state_reg == CLEAR);
   assign run            = (state_reg == RUN);
   assign fetch_ready    = run && (!fetch_valid_reg || fetch_accept);
   assign fetch_fire     = fetch_req && fetch_ready;
   assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_EXT);
   assign wr_in_range    = ({1'b0, wr_addr} < DEPTH_EXT);
   assign fetch_valid    = fetch_valid_reg;
   assign addr_err       = addr_err_reg;

   // The clear engine owns the single write port while busy; loader writes are dropped then.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
      mem_be    = wr_be;
      if (busy) begin
         mem_we    = 1'b1;
         mem_addr  = clr_cnt_reg;
         mem_wdata = '0;
         mem_be    = '1;
      end else if (wr_en && wr_in_range) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_valid_reg <= 1'b0;
         addr_err_reg    <= 1'b0;
      end else begin
         if (fetch_fire) begin
            fetch_valid_reg <= 1'b1;
         end else if (fetch_accept) begin
            fetch_valid_reg <= 1'b0;
         end
         addr_err_reg <= run && ((fetch_fire && !fetch_in_range) || (wr_en && !wr_in_range));
      end
   end

   // One narrow RAM per byte lane, so byte enables map onto independent write strobes.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [LW-1:0] lane_mem [DEPTH];
      logic [LW-1:0] wr_word;
      logic [7:0]    rd_byte_reg;
      logic          perr_reg;

`ifdef IM_PARITY_EN
      assign wr_word = {~busy & ((^mem_wdata[gi*8 +: 8]) ^ ((gi == 0) ? par_inject : 1'b0)),
                        mem_wdata[gi*8 +: 8]};
`else
      assign wr_word = mem_wdata[gi*8 +: 8];
`endif

      always_ff @(posedge clk) begin
         if (mem_we && mem_be[gi]) begin
            lane_mem[mem_addr] <= wr_word;
         end
      end

      // Read-first: this read sees the array contents from before any same-edge write.
      always_ff @(posedge clk) begin
         if (reset) begin
            rd_byte_reg <= 8'h00;
            perr_reg    <= 1'b0;
         end else begin
            perr_reg <= 1'b0;
            if (fetch_fire) begin
               rd_byte_reg <= fetch_in_range ? lane_mem[fetch_addr][7:0] : 8'h00;
`ifdef IM_PARITY_EN
               perr_reg    <= fetch_in_range && (^lane_mem[fetch_addr]);
`endif
            end
         end
      end

      assign fetch_data[gi*8 +: 8] = rd_byte_reg;
      assign lane_perr[gi]         = perr_reg;
   end

`ifdef IM_PARITY_EN
   assign par_err = |lane_perr;
`endif

endmodule

// File: tb/tb_im_fetch_mem.sv
// Scoreboard bench for im_fetch_mem: directed scenarios plus random traffic against a word-array model.
module tb_im_fetch_mem;

   localparam int DEPTH = 1000;
   localparam int AW    = 10;
   localparam int MAXA  = 1 << AW;

   typedef struct {
      int   due;
      logic val;
   } err_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_ready;
   logic          fetch_valid;
   logic [31:0]   fetch_data;
   logic          fetch_accept;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic [3:0]    wr_be;
   logic          busy;
   logic          addr_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   logic [31:0] model_mem [DEPTH];
   logic        model_valid;
   logic [31:0] data_q [$];
   err_t        err_q [$];

   im_fetch_mem #(.DATA_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_accept(fetch_accept),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .busy(busy), .addr_err(addr_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One bus cycle in RUN: drive, check ready against the model, record expectations.
   task automatic step(input logic req, input logic [AW-1:0] addr, input logic acc,
                       input logic we, input logic [AW-1:0] waddr,
                       input logic [31:0] wdata, input logic [3:0] be);
      logic exp_ready;
      logic fire;
      err_t e;
      @(negedge clk);
      fetch_req = req; fetch_addr = addr; fetch_accept = acc;
      wr_en = we; wr_addr = waddr; wr_data = wdata; wr_be = be;
      #1;
      exp_ready = !model_valid || acc;
      chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, exp_ready});
      fire = req && exp_ready;
      if (fire) data_q.push_back((int'(addr) < DEPTH) ? model_mem[addr] : 32'h0);
      e.due = cyc + 1;
      e.val = (fire && int'(addr) >= DEPTH) || (we && int'(waddr) >= DEPTH);
      err_q.push_back(e);
      if (we && int'(waddr) < DEPTH)
         for (int b = 0; b < 4; b++)
            if (be[b]) model_mem[waddr][b*8 +: 8] = wdata[b*8 +: 8];
      if (fire) model_valid = 1'b1;
      else if (acc) model_valid = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b1, 1'b0, '0, 32'h0, 4'h0);
   endtask

   task automatic fetch(input int a);
      step(1'b1, AW'(a), 1'b1, 1'b0, '0, 32'h0, 4'h0);
   endtask

   task automatic write(input int a, input logic [31:0] d, input logic [3:0] be);
      step(1'b0, '0, 1'b1, 1'b1, AW'(a), d, be);
   endtask

   // Reset, then watch the clear; optionally abort at abort_at and pulse writes during busy.
   task automatic reset_clear(input int abort_at, input int wr_at, input int wr_a);
      int n;
      int rdy_bad;
      int err_bad;
      @(negedge clk);
      reset = 1'b1; fetch_req = 1'b0; fetch_accept = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
      model_valid = 1'b0;
      n = 0; rdy_bad = 0; err_bad = 0;
      while (busy === 1'b1 && n < 2 * DEPTH) begin
         if (abort_at > 0 && n == abort_at) break;
         wr_en   = (n == wr_at) || (n == wr_at + 1);
         wr_addr = (n == wr_at) ? AW'(wr_a) : AW'(DEPTH + 5);
         wr_data = 32'hFFFF_FFFF;
         wr_be   = 4'hF;
         fetch_req = 1'b1; fetch_addr = AW'(n % DEPTH);
         #1;
         if (fetch_ready !== 1'b0) rdy_bad++;
         if (addr_err !== 1'b0) err_bad++;
         n++;
         @(negedge clk);
      end
      wr_en = 1'b0; fetch_req = 1'b0;
      if (abort_at == 0) chk("clear_len", n, DEPTH);
      chk("busy_ready_low", rdy_bad, 0);
      chk("busy_no_addr_err", err_bad, 0);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return AW'($urandom_range(DEPTH, MAXA - 1));
      return AW'($urandom_range(0, 15));
   endfunction

   // Monitor: compares the held output word every valid cycle and retires it on accept.
   initial begin
      wait (mon_en);
      forever begin
         @(negedge clk);
         #2;
         if (fetch_valid === 1'b1) begin
            if (data_q.size() == 0) begin
               chk("unexpected_fetch_valid", {31'b0, fetch_valid}, 32'h0);
            end else begin
               chk("fetch_data", fetch_data, data_q[0]);
               if (fetch_accept) void'(data_q.pop_front());
            end
         end
         while (err_q.size() > 0 && err_q[0].due <= cyc) begin
            chk("addr_err", {31'b0, addr_err}, {31'b0, err_q[0].val});
            void'(err_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation still running, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0; fetch_accept = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = 32'h0; wr_be = 4'h0;
      model_valid = 1'b0;

      reset_clear(0, -10, 0);
      mon_en = 1'b1;
      chk("post_clear_valid", {31'b0, fetch_valid}, 32'h0);

      fetch(DEPTH - 1);
      idle();

      write(5, 32'hDEAD_BEEF, 4'hF);
      write(6, 32'h1234_5678, 4'hF);
      fetch(5);
      fetch(6);
      idle();

      fetch(5);
      for (int i = 0; i < 3; i++) step(1'b1, AW'(6), 1'b0, 1'b0, '0, 32'h0, 4'h0);
      fetch(6);
      idle();

      step(1'b1, AW'(5), 1'b1, 1'b1, AW'(5), 32'h00AA_0000, 4'b0100);
      fetch(5);
      write(5, 32'h5555_5555, 4'h0);
      fetch(5);
      idle();

      reset_clear(500, 300, 7);
      reset_clear(0, 200, 9);
      fetch(7);
      fetch(9);
      fetch(5);
      idle();

      fetch(1003);
      idle();
      write(1003, 32'hFFFF_FFFF, 4'hF);
      idle();
      for (int i = 0; i < DEPTH; i++) fetch(i);
      idle();

      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0, rand_addr(), $urandom, 4'($urandom));
      idle();
      idle();
      @(negedge clk);
      #3;
      chk("scoreboard_empty", data_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
